// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Reads a multiplexed, active-low seven-segment display bus and keeps an
//   8-digit shadow of what is being shown. Every scan pattern must be stable
//   for SETTLE cycles before it is acted on. A pattern is acted on only once,
//   and only after it changes.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg[6:0]     segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   an[7:0]      digit scan {d7..d0}, active-low, one-hot-low when driving
//   digit_val    nibble i = decoded hex value of digit i
//   digit_valid  bit i = digit i last sampled with a legal, non-blank code
//   dp_val       bit i = decimal point of digit i lit at last sample
//   frame_done   one-cycle pulse once all 8 positions have been sampled
//   err          one-cycle pulse on an accepted illegal pattern
module seg_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [7:0]  an,
  output logic [31:0] digit_val,
  output logic [7:0]  digit_valid,
  output logic [7:0]  dp_val,
  output logic        frame_done,
  output logic        err
);

  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE);
  localparam logic [7:0] SETTLE_M1  = 8'(SETTLE - 1);

  // Returns {legal, value} for an active-low {g..a} pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: seg_decode = {1'b1, 4'h0};
      7'b1111001: seg_decode = {1'b1, 4'h1};
      7'b0100100: seg_decode = {1'b1, 4'h2};
      7'b0110000: seg_decode = {1'b1, 4'h3};
      7'b0011001: seg_decode = {1'b1, 4'h4};
      7'b0010010: seg_decode = {1'b1, 4'h5};
      7'b0000010: seg_decode = {1'b1, 4'h6};
      7'b1111000: seg_decode = {1'b1, 4'h7};
      7'b0000000: seg_decode = {1'b1, 4'h8};
      7'b0010000: seg_decode = {1'b1, 4'h9};
      7'b0001000: seg_decode = {1'b1, 4'hA};
      7'b0000011: seg_decode = {1'b1, 4'hB};
      7'b1000110: seg_decode = {1'b1, 4'hC};
      7'b0100001: seg_decode = {1'b1, 4'hD};
      7'b0000110: seg_decode = {1'b1, 4'hE};
      7'b0001110: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  // Synchronizer and stability tracker state; sampled word is {an, dp, seg}.
  logic [15:0] sync_p0, sync_p1;
  logic [15:0] prev;
  logic [7:0]  cnt;
  logic        armed;
  logic [7:0]  seen;

  logic        same, accept, one_low, legal;
  logic [7:0]  an_s;
  logic        dp_s;
  logic [6:0]  seg_s;
  logic [2:0]  idx;
  logic [3:0]  val;
  logic [7:0]  seen_next;

  always_comb begin
    same    = (sync_p1 == prev);
    // cnt reaches SETTLE on this edge with the pattern still unchanged.
    accept  = same && armed && (cnt == SETTLE_M1);
    an_s    = prev[15:8];
    dp_s    = prev[7];
    seg_s   = prev[6:0];
    one_low = $onehot(~an_s);
    idx     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_s[i]) idx = 3'(i);
    end
    {legal, val} = seg_decode(seg_s);
    seen_next    = seen | (8'b1 << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0     <= '1;
      sync_p1     <= '1;
      prev        <= '1;
      cnt         <= '0;
      armed       <= 1'b0;
      seen        <= '0;
      digit_val   <= '0;
      digit_valid <= '0;
      dp_val      <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop input synchronizer
      sync_p0    <= {an, dp, seg};
      sync_p1    <= sync_p0;
      frame_done <= 1'b0;
      err        <= 1'b0;

      // Stability tracking: a change re-arms and restarts the count
      if (!same) begin
        prev  <= sync_p1;
        cnt   <= 8'd1;
        armed <= 1'b1;
      end else if (cnt != SETTLE_MAX) begin
        cnt <= cnt + 8'd1;
      end

      // Accept: act on the settled pattern exactly once
      if (accept) begin
        armed <= 1'b0;
        if (an_s == 8'hFF) begin
          // blanking interval between digits: nothing to record
        end else if (one_low) begin
          dp_val[idx] <= ~dp_s;
          if (legal || seg_s == 7'h7F) begin
            // Blank digits count toward the frame; illegal codes do not,
            // which keeps err and frame_done mutually exclusive.
            if (legal) begin
              digit_val[{idx, 2'b00} +: 4] <= val;
              digit_valid[idx]             <= 1'b1;
            end else begin
              digit_valid[idx] <= 1'b0;
            end
            if (seen_next == 8'hFF) begin
              frame_done <= 1'b1;
              seen       <= '0;
            end else begin
              seen <= seen_next;
            end
          end else begin
            digit_valid[idx] <= 1'b0;
            err              <= 1'b1;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the CPU's multiplexed seven-segment display output. Samples the active-low segment bus and active-low digit-scan lines, waits for each scan pattern to settle, decodes the lit digit to a hex nibble, and maintains an 8-digit shadow of what the display shows. Used as a self-checking monitor in simulation and as a loopback reader on the board. Flags a frame once every digit position has been sampled.

## Interface
- SETTLE, 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg  in  7  segments {g,f,e,d,c,b,a}; active-low (0 = lit).
- dp  in  1  decimal point; active-low.
- an  in  8  digit scan {d7..d0}; active-low, one-hot-low when driving a digit.
- digit_val  out  32  nibble i = bits [4i+3:4i] = decoded value of digit i.
- digit_valid  out  8  bit i = digit i last sampled with a legal, non-blank code.
- dp_val  out  8  bit i = decimal point of digit i lit at last sample (active-high).
- frame_done  out  1  one-cycle pulse when all 8 positions sampled since the last pulse.
- err  out  1  one-cycle pulse on an accepted illegal pattern.

## Operation
- Input path: {an,dp,seg} pass through a 2-flop synchronizer, reset value all-ones (dark display).
- Stability tracker: prev register (reset all-ones) and counter cnt (reset 0, saturates at SETTLE). If sync output differs from prev: prev <= sync, cnt <= 1, armed <= 1. Otherwise cnt increments up to SETTLE.
- Accept: on the edge where cnt == SETTLE-1 and equal input is seen (cnt reaches SETTLE) with armed = 1, the pattern is accepted once; armed <= 0. No re-accept until the pattern changes.
- Accepted pattern, an classification:
  - all ones: blanking interval; ignored, no output change.
  - exactly one zero at position i: decode seg into slot i; dp_val[i] <= ~dp; seen[i] <= 1.
  - two or more zeros: err pulse; no slot updated; seen unchanged.
- Segment decode (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - legal code: digit_val slot <= value, digit_valid[i] <= 1.
  - 1111111 (blank digit): digit_valid[i] <= 0, slot value held, no err.
  - any other code: digit_valid[i] <= 0, slot value held, err pulse.
- Frame: when an accept sets the last zero bit of seen (seen becomes 8'hFF), frame_done pulses and seen clears to 0 on that same edge. Repeat visits to an already-seen slot update the slot but do not advance the frame.
- Reset (asserted at any time, including mid-settle or mid-frame): all outputs 0, seen 0, cnt 0, armed 0, synchronizer and prev all-ones. First accept after reset requires a pattern change.

## Timing
- Pin change captured by sync stage 1 on edge E0; outputs/pulses update on edge E0+SETTLE+1 if pins stay constant, i.e. latency SETTLE+1 cycles after capture.
- Any pattern held fewer than SETTLE cycles at the synchronizer output (glitch or scan transition) is never accepted.
- frame_done and err are each high exactly one cycle; both may assert on the same edge only if the err cause... never: err accepts do not set seen, so they are mutually exclusive.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: rst_n low with pins toggling -> all outputs 0; release, hold an=8'hFF -> no change, no pulses.
- Static digit: an=8'b1111_1110, seg=0110000, dp=0 held 10 cycles (SETTLE=4) -> digit_val[3:0]=3, digit_valid=8'h01, dp_val=8'h01, exactly one accept at capture+5.
- Full scan: drive digits 0..7 with codes 0..7, each 8 cycles separated by 2 blank cycles -> digit_val=32'h76543210, digit_valid=8'hFF, one frame_done pulse after digit 7, seen cleared.
- Glitch: 3-cycle pattern an=8'hFD, seg=0000000 between blanks (SETTLE=4) -> no slot 1 update, no pulses.
- Errors: an=8'hFC held -> one err pulse; an=8'hFE, seg=1010101 -> err pulse, digit_valid[0]=0, digit_val[3:0] unchanged; seg=1111111 -> digit_valid[0]=0, no err.
- Mid-frame reset: after 5 digits sampled, pulse rst_n low -> outputs 0; rescan all 8 -> single frame_done only after all 8 new samples.
